// File: rtl/mac_lane_feeder.sv
// MAC lane feeder: reads attribute/coefficient word pairs and streams them MSB-first as LANE_W lanes.
// Define FEEDER_PREFETCH_EN to overlap the next word's read with the current word's lanes.
module mac_lane_feeder #(
  parameter int ATTR_WIDTH      = 24,
  parameter int RAM2_DATA_WIDTH = 18,
  parameter int ADDR_WIDTH      = 8,
  parameter int LANE_W          = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [ADDR_WIDTH:0]        count,
  output logic                       busy,
  output logic                       done,
  output logic                       attr_rd_en,
  output logic [ADDR_WIDTH-1:0]      attr_addr,
  input  logic [ATTR_WIDTH-1:0]      attr_rdata,
  output logic                       coeff_rd_en,
  output logic [ADDR_WIDTH-1:0]      coeff_addr,
  input  logic [RAM2_DATA_WIDTH-1:0] coeff_rdata,
  output logic [LANE_W-1:0]          lane_a,
  output logic [LANE_W-1:0]          lane_b,
  output logic                       lane_valid,
  input  logic                       lane_ready,
  output logic                       lane_first,
  output logic                       lane_last,
  output logic                       vec_last
);

  localparam int MAXW   = (ATTR_WIDTH > RAM2_DATA_WIDTH) ? ATTR_WIDTH : RAM2_DATA_WIDTH;
  localparam int NLANES = (MAXW + LANE_W - 1) / LANE_W;
  localparam int PW     = NLANES * LANE_W;
  localparam int IW     = (NLANES > 2) ? $clog2(NLANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NLANES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [ADDR_WIDTH:0]   rem_p0;
  logic [IW-1:0]         idx_p1;
  logic [PW-1:0]         sh_a_p1, sh_b_p1;
  logic [PW-1:0]         ext_a, ext_b;
  logic                  hs, is_last, more, rd_any;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Zero-extend both words on the left to the full lane span.
  always_comb begin
    ext_a = '0;
    ext_a[ATTR_WIDTH-1:0] = attr_rdata;
    ext_b = '0;
    ext_b[RAM2_DATA_WIDTH-1:0] = coeff_rdata;
  end

  assign hs      = lane_valid & lane_ready;
  assign is_last = (idx_p1 == LAST_IDX);

`ifdef FEEDER_PREFETCH_EN
  logic          pf_rd, pf_pend_p1, pf_got_p1;
  logic [PW-1:0] stg_a_p2, stg_b_p2;

  assign pf_rd   = hs && (idx_p1 == '0) && (rem_p0 != '0);
  assign more    = pf_got_p1;
  assign rd_any  = (state == FETCH) | pf_rd;
  assign rd_addr = pf_rd ? addr_p0 + ADDR_WIDTH'(1) : addr_p0;

  // Staging: rdata lands the cycle after the prefetch strobe and is held until the word switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_pend_p1 <= 1'b0;
      pf_got_p1  <= 1'b0;
      stg_a_p2   <= '0;
      stg_b_p2   <= '0;
    end else begin
      pf_pend_p1 <= pf_rd;
      if (pf_pend_p1) begin
        stg_a_p2 <= ext_a;
        stg_b_p2 <= ext_b;
      end
      if (pf_rd)
        pf_got_p1 <= 1'b1;
      else if (hs && is_last)
        pf_got_p1 <= 1'b0;
    end
  end
`else
  assign more    = (rem_p0 != '0);
  assign rd_any  = (state == FETCH);
  assign rd_addr = addr_p0;
`endif

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign attr_rd_en  = rd_any;
  assign coeff_rd_en = rd_any;
  assign attr_addr   = rd_addr;
  assign coeff_addr  = rd_addr;
  assign lane_valid  = (state == SHIFT);
  assign lane_a      = sh_a_p1[PW-1 -: LANE_W];
  assign lane_b      = sh_b_p1[PW-1 -: LANE_W];
  assign lane_first  = lane_valid && (idx_p1 == '0);
  assign lane_last   = lane_valid && is_last;
  assign vec_last    = lane_last && !more;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (count != '0) ? FETCH : DONE;
      FETCH: state_nx = WAIT;
      WAIT:  state_nx = SHIFT;
      SHIFT: if (hs && is_last) begin
`ifdef FEEDER_PREFETCH_EN
               state_nx = more ? SHIFT : DONE;
`else
               state_nx = more ? FETCH : DONE;
`endif
             end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // p0: address/remaining bookkeeping; p1: lane shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0 <= '0;
      rem_p0  <= '0;
      idx_p1  <= '0;
      sh_a_p1 <= '0;
      sh_b_p1 <= '0;
    end else begin
      case (state)
        IDLE: if (start && count != '0) begin
          addr_p0 <= base_addr;
          rem_p0  <= count - (ADDR_WIDTH+1)'(1);
        end
        WAIT: begin
          sh_a_p1 <= ext_a;
          sh_b_p1 <= ext_b;
          idx_p1  <= '0;
        end
        SHIFT: if (hs) begin
          if (!is_last) begin
            idx_p1  <= idx_p1 + IW'(1);
            sh_a_p1 <= sh_a_p1 << LANE_W;
            sh_b_p1 <= sh_b_p1 << LANE_W;
          end
`ifdef FEEDER_PREFETCH_EN
          else if (more) begin
            sh_a_p1 <= pf_pend_p1 ? ext_a : stg_a_p2;
            sh_b_p1 <= pf_pend_p1 ? ext_b : stg_b_p2;
            idx_p1  <= '0;
          end
`else
          else if (more) begin
            addr_p0 <= addr_p0 + ADDR_WIDTH'(1);
            rem_p0  <= rem_p0 - (ADDR_WIDTH+1)'(1);
          end
`endif
        end
        default: ;
      endcase
`ifdef FEEDER_PREFETCH_EN
      if (pf_rd) begin
        addr_p0 <= rd_addr;
        rem_p0  <= rem_p0 - (ADDR_WIDTH+1)'(1);
      end
`endif
    end
  end

endmodule

// File: doc/mac_lane_feeder.md
Name: mac_lane_feeder

Overview:
- Producer side of the MAC lane interface: fetches attribute/coefficient word pairs from the attribute RAM and coefficient RAM.
- Splits each pair into 8-bit lanes, MSB first, and streams them to the multiply-accumulate unit over a valid/ready handshake.
- Marks the first lane of each word, the last lane of each word and the last lane of the whole vector, so the consumer can clear and latch its accumulator.

Parameters:
- ATTR_WIDTH, 24, attribute word width.
- RAM2_DATA_WIDTH, 18, coefficient word width.
- ADDR_WIDTH, 8, RAM address width.
- LANE_W, 8, lane width. Derived: NLANES = ceil(max(ATTR_WIDTH, RAM2_DATA_WIDTH)/LANE_W), 3 at defaults, required ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin vector; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address, shared by both RAMs.
- count  in  ADDR_WIDTH+1  number of word pairs (0..2^ADDR_WIDTH).
- busy  out  1  high from the edge that accepts start until done.
- done  out  1  one-cycle pulse when the vector completes.
- attr_rd_en  out  1  attribute RAM read strobe.
- attr_addr  out  ADDR_WIDTH  attribute RAM address.
- attr_rdata  in  ATTR_WIDTH  attribute data; valid the cycle after attr_rd_en.
- coeff_rd_en  out  1  coefficient RAM read strobe.
- coeff_addr  out  ADDR_WIDTH  coefficient RAM address.
- coeff_rdata  in  RAM2_DATA_WIDTH  coefficient data; valid the cycle after coeff_rd_en.
- lane_a  out  LANE_W  attribute lane.
- lane_b  out  LANE_W  coefficient lane.
- lane_valid  out  1  lane present.
- lane_ready  in  1  consumer accepts the lane.
- lane_first  out  1  lane 0 of a word.
- lane_last  out  1  lane NLANES-1 of a word.
- vec_last  out  1  last lane of the last word.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. All outputs 0: busy, done, rd_en strobes, addresses, lanes, valid and all flags. Shift and staging registers are cleared.
- Padding: both words are zero-extended on the left to NLANES*LANE_W bits. Lane k carries slice [(NLANES-k)*LANE_W-1 : (NLANES-k-1)*LANE_W].
- FSM states: IDLE, FETCH, WAIT, SHIFT, DONE.
- IDLE:
  - start=1, count≠0: latch base_addr and count, busy=1, go to FETCH.
  - start=1, count=0: go to DONE; no reads, no lanes.
- FETCH: attr_rd_en = coeff_rd_en = 1, both addresses = current address, go to WAIT.
- WAIT: at the end of the cycle, capture rdata into the shift registers and set lane index = 0, go to SHIFT.
- SHIFT:
  - lane_valid = 1; lane_first = (idx==0); lane_last = (idx==NLANES-1); vec_last = lane_last and no words remaining.
  - A handshake occurs when lane_valid & lane_ready.
  - On a handshake with idx<NLANES-1: idx increments.
  - On a handshake with idx=NLANES-1:
    - words remain: increment the address and go to FETCH.
    - no words remain: go to DONE.
  - lane_ready=0: outputs hold stable, no state change.
- DONE: done=1 for one cycle, busy falls at the same edge done falls, go to IDLE.
- Latency without prefetch: start accepted at edge E0 → rd_en high after E0 → first lane_valid after E2. Each word costs NLANES+2 cycles with lane_ready held high.
- Addresses wrap modulo 2^ADDR_WIDTH. count = 2^ADDR_WIDTH reads every location once.
- start while busy is ignored. base_addr and count changes while busy are ignored.
- rst_n asserted mid-vector: immediate return to IDLE, lane_valid drops, no done pulse.

Optional Feature:
- Macro: FEEDER_PREFETCH_EN.
- Defined:
  - On the handshake of lane 0 of a word, if words remain, the next read is issued (next address).
  - rdata is captured into a staging register the following cycle.
  - On the last-lane handshake, the shift registers load from staging and SHIFT continues at idx 0, skipping FETCH/WAIT.
  - With lane_ready tied high, lane_valid stays high continuously from the first lane to vec_last; each word costs NLANES cycles.
  - Staging data is held across lane_ready stalls.
- Undefined: no staging register; behaviour as above.

Test Plan:
- Setup: attr RAM[4]=0xA1B2C3, coeff RAM[4]=0x2ABCD. Stimulus: start, base_addr=4, count=1, lane_ready=1. Response:
  - lane_a 0xA1, 0xB2, 0xC3 with lane_b 0x02, 0xAB, 0xCD.
  - lane_first on lane 0; lane_last and vec_last on lane 2.
  - first lane_valid 2 cycles after start is accepted; done 1 cycle after the last handshake.
- count=0 -> no rd_en and no lane_valid; done pulses exactly once and busy lasts 1 cycle.
- base_addr=0xFE, count=3 -> reads at 0xFE, 0xFF, 0x00; vec_last only on lane 2 of the third word; 9 handshakes total.
- lane_ready toggled 1,0,0,1,… during SHIFT -> lane_a/lane_b/flags stable while ready=0; no lane lost or duplicated.
- rst_n pulsed low mid-word 2 of count=4 -> all outputs 0 immediately; no done. A new start then streams correctly from its own base_addr.
- FEEDER_PREFETCH_EN, count=4, lane_ready=1 -> 12 consecutive valid cycles with no bubble; the read for word n+1 is issued on the lane 0 handshake of word n.
